// File: rtl/pe_ws.sv
// Weight-stationary MAC processing element for systolic arrays (fixed-point Q format).
// Optional feature: define PE_SAT_EN to saturate y_out on overflow instead of wrapping.
module pe_ws #(
  parameter int WIDTH    = 16,
  parameter int FRAC_BIT = 10   // legal range 0..WIDTH-1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             w_load,
  input  logic [WIDTH-1:0] w_in,
  output logic [WIDTH-1:0] w_out,
  output logic             w_valid,
  input  logic             a_valid_in,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] y_in,
  output logic             a_valid_out,
  output logic [WIDTH-1:0] a_out,
  output logic [WIDTH-1:0] y_out,
  input  logic             ovf_clr,
  output logic             ovf
);

  localparam int SW = WIDTH + 2;

  // Handshake: a_valid_in qualifies a_in/y_in in the cycle it is high; there is
  // no backpressure, every stage accepts one beat per clock and forwards it one
  // cycle later on a_valid_out/a_out/y_out.

  logic signed [WIDTH-1:0]   r_weight;
  logic                      r_w_valid;
  logic                      r_a_valid;
  logic        [WIDTH-1:0]   r_a;
  logic        [WIDTH-1:0]   r_y;
  logic                      r_ovf;

  logic signed [2*WIDTH-1:0] w_prod;
  logic signed [SW-1:0]      w_sum;
  logic                      w_mac;
  logic                      w_range_err;
  logic                      w_ovf_evt;
  logic        [WIDTH-1:0]   w_mac_y;

  assign w_prod = $signed(a_in) * r_weight;
  // Floor shift of the full product; the sum is then formed in WIDTH+2 bits.
  assign w_sum  = SW'(w_prod >>> FRAC_BIT) + SW'($signed(y_in));

  assign w_mac       = a_valid_in & r_w_valid;
  // In range iff the bits from WIDTH-1 upward are all equal.
  assign w_range_err = ~((&w_sum[SW-1:WIDTH-1]) | ~(|w_sum[SW-1:WIDTH-1]));
  assign w_ovf_evt   = w_mac & w_range_err;

`ifdef PE_SAT_EN
  always_comb begin
    w_mac_y = w_sum[WIDTH-1:0];
    if (w_range_err) begin
      w_mac_y = w_sum[SW-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
    end
  end
`else
  assign w_mac_y = w_sum[WIDTH-1:0];
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_weight  <= '0;
      r_w_valid <= 1'b0;
      r_a_valid <= 1'b0;
      r_a       <= '0;
      r_y       <= '0;
      r_ovf     <= 1'b0;
    end else begin
      // The MAC above reads r_weight before this edge, so a same-cycle load
      // only takes effect for the following beat.
      if (w_load) begin
        r_weight  <= $signed(w_in);
        r_w_valid <= 1'b1;
      end
      r_a_valid <= a_valid_in;
      r_a       <= a_in;
      r_y       <= w_mac ? w_mac_y : y_in;
      // Set wins over clear.
      if (w_ovf_evt) begin
        r_ovf <= 1'b1;
      end else if (ovf_clr) begin
        r_ovf <= 1'b0;
      end
    end
  end

  assign w_out       = r_weight;
  assign w_valid     = r_w_valid;
  assign a_valid_out = r_a_valid;
  assign a_out       = r_a;
  assign y_out       = r_y;
  assign ovf         = r_ovf;

endmodule

// File: doc/pe_ws.md
PE_WS -- requirements
Module: pe_ws

Interface
REQ-001 Parameter WIDTH, default 16, signed two's-complement data width of every data port.
REQ-002 Parameter FRAC_BIT, default 10, fractional bits of the fixed-point format (Q(WIDTH-FRAC_BIT).FRAC_BIT); legal range 0..WIDTH-1.
REQ-003 Port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 Port rst  input  1  reset, asynchronous, active-high.
REQ-005 Port w_load  input  1  weight-load strobe.
REQ-006 Port w_in  input  WIDTH  weight data, from the column neighbour above.
REQ-007 Port w_out  output  WIDTH  held weight, to the column neighbour below (shift chain).
REQ-008 Port w_valid  output  1  high once a weight has been loaded.
REQ-009 Port a_valid_in  input  1  qualifies a_in/y_in.
REQ-010 Port a_in  input  WIDTH  activation from the left neighbour.
REQ-011 Port y_in  input  WIDTH  partial sum from the neighbour above.
REQ-012 Port a_valid_out  output  1  registered a_valid_in.
REQ-013 Port a_out  output  WIDTH  registered a_in, to the right neighbour.
REQ-014 Port y_out  output  WIDTH  registered partial sum, to the neighbour below.
REQ-015 Port ovf_clr  input  1  clears the sticky overflow flag.
REQ-016 Port ovf  output  1  sticky overflow flag.

Function
REQ-017 Weight register: when w_load=1, weight <= w_in and w_valid <= 1 on the clock edge; otherwise weight holds; w_out = weight (combinational from register).
REQ-018 Weight chain: N PEs chained w_out->w_in load N weights in N cycles of w_load=1, first weight ending in the last PE.
REQ-019 Datapath latency exactly 1 cycle: a_out, a_valid_out, y_out register values sampled at the same edge.
REQ-020 a_out <= a_in and a_valid_out <= a_valid_in every cycle, regardless of a_valid_in or w_valid.
REQ-021 When a_valid_in=1 and w_valid=1: y_out <= fmt(a_in*weight) + y_in.
REQ-022 fmt: full 2*WIDTH signed product, arithmetic right shift by FRAC_BIT (floor toward -infinity, no rounding), sum formed at WIDTH+2 bits before narrowing.
REQ-023 When a_valid_in=0, or w_valid=0: y_out <= y_in unchanged (bubble/pass-through), ovf unaffected.
REQ-024 Simultaneous w_load and a_valid_in: MAC uses the weight held before the edge; new weight applies from the next cycle.
REQ-025 Overflow event: wide sum outside [-2^(WIDTH-1), 2^(WIDTH-1)-1] during a MAC per REQ-021.
REQ-026 ovf sets on an overflow event, clears on ovf_clr=1; simultaneous set and clear -> ovf=1.

Reset
REQ-027 rst=1 forces asynchronously: weight=0, w_valid=0, a_out=0, a_valid_out=0, y_out=0, ovf=0.
REQ-028 Reset asserted mid-stream discards any in-flight result; after release, first MAC requires a new w_load.
REQ-029 Inputs are ignored while rst=1; first capture on the first rising edge after deassertion.

Configuration
REQ-030 Macro PE_SAT_EN defined: on overflow, y_out saturates to 2^(WIDTH-1)-1 (positive) or -2^(WIDTH-1) (negative).
REQ-031 Macro PE_SAT_EN undefined: y_out is the low WIDTH bits of the wide sum (wrap); ovf still flags per REQ-025/026.

Verification (WIDTH=16, FRAC_BIT=10)
REQ-032 Load w_in=0x0800 (2.0); a_in=0x0600 (1.5), y_in=0x0000, valid -> next cycle y_out=0x0C00, a_out=0x0600, a_valid_out=1, ovf=0.
REQ-033 Weight 0xFC00 (-1.0); a_in=0xF000 (-4), y_in=0x0400 (1) -> y_out=0x1400 (5.0); weight 0x0800, a_in=0xFB33 -> y_out=0xF666 (floor).
REQ-034 Weight 0x0800; a_in=0x7C00 (31.0), y_in=0 -> with PE_SAT_EN y_out=0x7FFF, ovf=1; without it y_out=0xF800, ovf=1; then ovf_clr=1 -> ovf=0.
REQ-035 Same cycle w_load (w_in=0x0C00) and MAC with old weight 0x0400, a_in=0x0400, y_in=0 -> y_out=0x0400; next MAC same inputs -> y_out=0x0C00.
REQ-036 No weight loaded or a_valid_in=0 with y_in=0x1A00 -> y_out=0x1A00, a_valid_out=0; chain of 2 PEs, w_load 2 cycles with 0x0400 then 0x0800 -> PE0 weight 0x0800, PE1 0x0400.
REQ-037 Assert rst between two valid MAC cycles -> all outputs 0 immediately (asynchronous), w_valid=0, subsequent MAC passes y_in through until reloaded.
